// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC/IR sequencer with req/ack instruction fetch; optional `FETCH_SINGLE_STEP_EN` adds a step input.
module fetch_sequencer #(
  parameter int ADDR_W = 4,
  parameter int INSTR_W = 8,
  parameter logic [3:0] HALT_OP = 4'b1111
) (
  input  logic               clk,
  input  logic               reset,
`ifdef FETCH_SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [3:0]         opcode,
  output logic [3:0]         imm,
  output logic               instr_valid,
  output logic               zf,
  input  logic               jmp_sel,
  input  logic               reg_en,
  input  logic               alu_zf,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
  state_t r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic r_zf, r_halted, r_req, r_valid;
  logic w_go, w_ss;
  logic [ADDR_W-1:0] w_next_pc;
`ifdef FETCH_SINGLE_STEP_EN
  assign w_go = step;
  assign w_ss = 1'b1;
`else
  assign w_go = 1'b1;
  assign w_ss = 1'b0;
`endif
  assign w_next_pc = jmp_sel ? ADDR_W'(r_ir[3:0]) : r_pc + ADDR_W'(1);
  assign imem_req = r_req;
  assign imem_addr = r_pc;
  assign pc = r_pc;
  assign opcode = r_ir[INSTR_W-1 -: 4];
  assign imm = r_ir[3:0];
  assign instr_valid = r_valid;
  assign zf = r_zf;
  assign halted = r_halted;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc <= '0;
      r_ir <= '0;
      r_zf <= 1'b0;
      r_halted <= 1'b0;
      r_req <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_go) begin
          r_state <= FETCH;
          r_req <= 1'b1;
        end
        FETCH: if (imem_ack) begin
          r_ir <= imem_rdata;
          r_state <= EXEC;
          r_req <= 1'b0;
          r_valid <= 1'b1;
        end
        EXEC: begin
          r_valid <= 1'b0;
          if (opcode == HALT_OP) begin
            r_halted <= 1'b1;
            r_state <= HALT;
          end else begin
            r_pc <= w_next_pc;
            r_zf <= reg_en ? alu_zf : r_zf;
            r_state <= w_ss ? IDLE : FETCH;
            r_req <= !w_ss;
          end
        end
        default: r_state <= HALT;
      endcase
    end
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction fetch and sequencing engine for the 4-bit-opcode datapath. It holds the PC, fetches 8-bit instruction words over a req/ack memory handshake, and presents opcode and immediate to the combinational control unit. It consumes the control unit's jump-select and register-enable decisions to advance the PC, and keeps the registered zero flag that the control unit uses for conditional jumps.

Parameters:
ADDR_W, 4, PC and instruction-memory address width; PC wraps modulo 2^ADDR_W.
INSTR_W, 8, instruction width; [7:4] is the opcode, [3:0] is the immediate or jump target.
HALT_OP, 4'b1111, opcode that stops sequencing.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
imem_req  output  1  fetch request, held until acknowledged.
imem_addr  output  ADDR_W  fetch address, equal to the PC.
imem_ack  input  1  fetch complete; imem_rdata is valid in the same cycle.
imem_rdata  input  INSTR_W  fetched instruction word.
opcode  output  4  IR[7:4], driven to the control unit.
imm  output  4  IR[3:0], immediate or jump target.
instr_valid  output  1  high for exactly the EXEC cycle; qualifies all control-unit outputs.
zf  output  1  registered zero flag, driven to the control unit's ZF input.
jmp_sel  input  1  from the control unit; load PC with the target.
reg_en  input  1  from the control unit; the instruction writes the register file.
alu_zf  input  1  combinational ALU zero result for the current instruction.
pc  output  ADDR_W  current PC.
halted  output  1  high once HALT_OP has executed.

Behaviour:
- Clock and reset: single clock `clk`. `reset` is synchronous and active-high.
- Reset values (takes effect on the edge where reset is sampled high, from any state, including mid-FETCH):
  - state=IDLE, pc=0, IR=0 (so opcode=0 and imm=0).
  - imem_req=0, instr_valid=0, zf=0, halted=0.
- IDLE: lasts one cycle, then moves to FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - On imem_ack: IR <= imem_rdata, go to EXEC.
  - The ack may arrive in the first FETCH cycle, so the minimum is 2 cycles per instruction.
  - imem_ack sampled in any other state is ignored.
- EXEC (one cycle):
  - instr_valid=1; jmp_sel, reg_en and alu_zf are sampled at the end of the cycle.
  - If opcode==HALT_OP: halted<=1, go to HALT. The PC and zf are not updated.
  - Otherwise the PC update is: pc <= jmp_sel ? imm zero-extended (or truncated) to ADDR_W : pc+1 modulo 2^ADDR_W.
  - If reg_en: zf <= alu_zf. Otherwise zf holds.
  - Next state is FETCH.
- HALT: terminal state. imem_req=0, instr_valid=0, all registers hold; only reset exits.
- jmp_sel and reg_en are don't-care outside EXEC.
- The conditional jump uses the zf value registered by the last register-writing instruction, never alu_zf of the jump itself.
- imem_req deasserts in the cycle after ack (the EXEC cycle).

Optional Feature:
- Macro: FETCH_SINGLE_STEP_EN.
- When defined:
  - Adds input `step` (1 bit).
  - IDLE is re-entered after every EXEC instead of going straight to FETCH.
  - Leaving IDLE requires step=1 in that cycle, so each step pulse executes exactly one instruction.
  - After reset the block waits for the first step.
- When undefined: there is no step port and IDLE always lasts exactly one cycle, as above.

Test Plan:
1. Reset for 2 cycles, then memory acks in the same cycle as req with words 0x03, 0x12, 0x21 -> imem_addr sequence 0,1,2; instr_valid pulses every 2nd cycle; opcode 0,1,2 in turn; pc ends at 3.
2. Word 0x8A at address 2, control unit returns jmp_sel=1 in EXEC -> next imem_addr=0xA; zf unchanged.
3. Conditional jump:
   - Stimulus: 0x00 with reg_en=1 and alu_zf=1, then 0x95 with jmp_sel following zf.
   - Required response: zf=1 after the first EXEC; next fetch address is 5.
   - Repeat with alu_zf=0: zf=0, and the fetch after 0x95 is pc+1.
4. pc=0xF with non-jump word 0x00 -> next imem_addr=0x0 (wrap).
5. Ack delayed 3 cycles with rdata toggling before ack:
   - imem_req and imem_addr are stable for all 4 FETCH cycles.
   - IR equals rdata only from the ack cycle.
   - A stray imem_ack during EXEC is ignored.
6. Reset mid-operation and halt:
   - Reset asserted in the second FETCH cycle of address 3 -> next cycle imem_req=0 and pc=0; fetch resumes at 0 after IDLE.
   - Word 0xF0 -> halted=1; no further imem_req for 20 cycles; pc holds.
